mod12_count_monitor: RTL and testbench

- Passive checker that sits on the control and output pins of the mod-12 up/down counter. It is the observing end of the counter's load/upd interface.
- Each cycle it samples reset, load, data_in, upd and count, and predicts the next count from them. It then compares the observed count against that prediction.
- It flags mismatches, out-of-range values and wrap events, and it loses lock and re-acquires lock autonomously.
- Instantiated alongside the counter in the block-level bench and in the debug build of the top level.

---
 rtl/mod12_mon_pkg.sv | 28 ++
 rtl/mod12_count_monitor_sva.sv | 30 +++
 rtl/mod12_count_monitor.sv | 149 ++++++++++++++
 tb/tb_mod12_count_monitor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mod12_mon_pkg.sv
// Shared types and the next-count prediction model for the mod-12 counter monitor.
// The same mod12_next function feeds both the RTL monitor and any bench scoreboard.
package mod12_mon_pkg;

  localparam int unsigned MOD12_MAX = 32'd11;
  localparam int unsigned MON_WIDTH = 32'd4;

  typedef enum logic [0:0] {SYNC = 1'b0, LOST = 1'b1} mon_state_t;

  // Next count of the observed counter, reset excluded; base is always the observed count.
  function automatic logic [MON_WIDTH-1:0] mod12_next(
    input logic [MON_WIDTH-1:0] count,
    input logic                 load,
    input logic [MON_WIDTH-1:0] data_in,
    input logic                 upd
  );
    logic [MON_WIDTH-1:0] nxt;
    if (load) begin
      nxt = data_in;
    end else if (upd) begin
      nxt = (count == MON_WIDTH'(MOD12_MAX)) ? {MON_WIDTH{1'b0}} : count + MON_WIDTH'(1'b1);
    end else begin
      nxt = (count == {MON_WIDTH{1'b0}}) ? MON_WIDTH'(MOD12_MAX) : count - MON_WIDTH'(1'b1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mod12_count_monitor_sva.sv
// Simulation-only property checker for mod12_count_monitor.
// Present only when MOD12_MON_ASSERT_EN is defined.
`ifdef MOD12_MON_ASSERT_EN
module mod12_count_monitor_sva #(
  parameter int unsigned WIDTH     = 32'd4,
  parameter int unsigned ERR_CNT_W = 32'd8
) (
  input logic                 clock,
  input logic                 reset,
  input logic [WIDTH-1:0]     count,
  input logic [WIDTH-1:0]     expected,
  input logic                 mismatch,
  input logic [ERR_CNT_W-1:0] err_count,
  input logic                 wrap_up,
  input logic                 wrap_dn
);

  a_no_mismatch_after_reset: assert property (@(posedge clock) $past(reset) |-> !mismatch);

  a_err_count_monotonic: assert property (@(posedge clock)
    !$past(reset) |-> (err_count >= $past(err_count)));

  a_wrap_exclusive: assert property (@(posedge clock) !(wrap_up && wrap_dn));

  // The flagged values are the ones compared one cycle before the pulse.
  a_report_mismatch: assert property (@(posedge clock) disable iff (reset) !mismatch)
    else $error("count monitor: expected %0d observed %0d", $past(expected), $past(count));

endmodule
`endif

// File: rtl/mod12_count_monitor.sv
// Passive lock/compare monitor for the mod-12 up/down counter (load/upd interface).
// Optional simulation assertions are bound in with MOD12_MON_ASSERT_EN.
module mod12_count_monitor
  import mod12_mon_pkg::*;
#(
  parameter int unsigned MODULUS   = 32'd12,
  parameter int unsigned WIDTH     = 32'd4,
  parameter int unsigned ERR_CNT_W = 32'd8,
  parameter int unsigned RESYNC_N  = 32'd3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 upd,
  input  logic [WIDTH-1:0]     count,
  output logic [WIDTH-1:0]     expected,
  output logic                 locked,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_up,
  output logic                 wrap_dn,
  output logic                 illegal_value
);

  localparam int unsigned        MATCH_W    = (RESYNC_N > 32'd1) ? $clog2(RESYNC_N) : 32'd1;
  localparam logic [WIDTH-1:0]   TOP_VAL    = WIDTH'(MODULUS - 32'd1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(RESYNC_N - 32'd1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  mon_state_t           state_r, state_s;
  logic [MATCH_W-1:0]   match_cnt_r, match_cnt_s;
  logic [ERR_CNT_W-1:0] err_count_r, err_count_s;
  logic [WIDTH-1:0]     expected_r, pred_s;
  logic                 rst_d_r;
  logic                 wrap_up_arm_r, wrap_dn_arm_r;
  logic                 wrap_up_arm_s, wrap_dn_arm_s;
  logic                 mismatch_r, mismatch_s;
  logic                 wrap_up_r, wrap_up_s;
  logic                 wrap_dn_r, wrap_dn_s;
  logic                 illegal_r, illegal_s;
  logic                 skip_s, hit_s;

  // Prediction, comparison and wrap/illegal detection for the current cycle.
  always_comb begin
    pred_s        = WIDTH'(mod12_next(MON_WIDTH'(count), load, MON_WIDTH'(data_in), upd));
    skip_s        = reset | rst_d_r;
    hit_s         = skip_s | (count == expected_r);
    wrap_up_arm_s = ~reset & ~load & upd & (count == TOP_VAL);
    wrap_dn_arm_s = ~reset & ~load & ~upd & (count == {WIDTH{1'b0}});
    wrap_up_s     = ~reset & wrap_up_arm_r & (count == {WIDTH{1'b0}});
    wrap_dn_s     = ~reset & wrap_dn_arm_r & (count == TOP_VAL);
    illegal_s     = ~reset & (32'(count) >= MODULUS);
  end

  // Lock FSM next state, resync counter and saturating error count.
  always_comb begin
    state_s     = state_r;
    match_cnt_s = match_cnt_r;
    err_count_s = err_count_r;
    mismatch_s  = 1'b0;
    case (state_r)
      SYNC: begin
        if (!hit_s) begin
          mismatch_s  = 1'b1;
          state_s     = LOST;
          match_cnt_s = {MATCH_W{1'b0}};
          if (err_count_r != ERR_MAX) begin
            err_count_s = err_count_r + ERR_CNT_W'(1'b1);
          end else begin
            err_count_s = err_count_r;
          end
        end else begin
          state_s = SYNC;
        end
      end
      LOST: begin
        if (hit_s) begin
          if (match_cnt_r == MATCH_LAST) begin
            state_s     = SYNC;
            match_cnt_s = {MATCH_W{1'b0}};
          end else begin
            match_cnt_s = match_cnt_r + MATCH_W'(1'b1);
          end
        end else begin
          match_cnt_s = {MATCH_W{1'b0}};
        end
      end
      default: begin
        state_s     = SYNC;
        match_cnt_s = {MATCH_W{1'b0}};
      end
    endcase
  end

  // State, prediction and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= SYNC;
      match_cnt_r   <= {MATCH_W{1'b0}};
      err_count_r   <= {ERR_CNT_W{1'b0}};
      expected_r    <= {WIDTH{1'b0}};
      rst_d_r       <= 1'b1;
      wrap_up_arm_r <= 1'b0;
      wrap_dn_arm_r <= 1'b0;
      mismatch_r    <= 1'b0;
      wrap_up_r     <= 1'b0;
      wrap_dn_r     <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      match_cnt_r   <= match_cnt_s;
      err_count_r   <= err_count_s;
      expected_r    <= pred_s;
      rst_d_r       <= 1'b0;
      wrap_up_arm_r <= wrap_up_arm_s;
      wrap_dn_arm_r <= wrap_dn_arm_s;
      mismatch_r    <= mismatch_s;
      wrap_up_r     <= wrap_up_s;
      wrap_dn_r     <= wrap_dn_s;
      illegal_r     <= illegal_s;
    end
  end

  assign expected      = expected_r;
  assign locked        = (state_r == SYNC);
  assign mismatch      = mismatch_r;
  assign err_count     = err_count_r;
  assign wrap_up       = wrap_up_r;
  assign wrap_dn       = wrap_dn_r;
  assign illegal_value = illegal_r;

`ifdef MOD12_MON_ASSERT_EN
  mod12_count_monitor_sva #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_sva (
    .clock     (clock),
    .reset     (reset),
    .count     (count),
    .expected  (expected_r),
    .mismatch  (mismatch_r),
    .err_count (err_count_r),
    .wrap_up   (wrap_up_r),
    .wrap_dn   (wrap_dn_r)
  );
`endif

endmodule

// File: tb/tb_mod12_count_monitor.sv
// Directed self-checking bench for mod12_count_monitor; the bench plays the counter on count.
module tb_mod12_count_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       upd = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic [3:0] count = 4'd0;
  logic [3:0] expected;
  logic       locked, mismatch, wrap_up, wrap_dn, illegal_value;
  logic [7:0] err_count;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int wu_seen, mm_seen;

  mod12_count_monitor dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .data_in       (data_in),
    .upd           (upd),
    .count         (count),
    .expected      (expected),
    .locked        (locked),
    .mismatch      (mismatch),
    .err_count     (err_count),
    .wrap_up       (wrap_up),
    .wrap_dn       (wrap_dn),
    .illegal_value (illegal_value)
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs, then sample just after the closing edge.
  task automatic tick(input logic r, input logic ld, input logic [3:0] d,
                      input logic u, input logic [3:0] c);
    reset = r; load = ld; data_in = d; upd = u; count = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e, input logic lk, input logic mm,
                         input logic [7:0] ec, input logic wu, input logic wd, input logic il);
    chk({tag, ".expected"}, 16'(expected), 16'(e));
    chk({tag, ".locked"},   16'(locked), 16'(lk));
    chk({tag, ".mismatch"}, 16'(mismatch), 16'(mm));
    chk({tag, ".err"},      16'(err_count), 16'(ec));
    chk({tag, ".wrap_up"},  16'(wrap_up), 16'(wu));
    chk({tag, ".wrap_dn"},  16'(wrap_dn), 16'(wd));
    chk({tag, ".illegal"},  16'(illegal_value), 16'(il));
  endtask

  initial begin
    logic [3:0] c;

    tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    chk_all("reset", 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Count up 0..11,0,1: one wrap_up, seen after the cycle showing 0.
    wu_seen = 0;
    for (int i = 0; i < 14; i++) begin
      c = 4'(i % 12);
      tick(1'b0, 1'b0, 4'd0, 1'b1, c);
      wu_seen += int'(wrap_up);
      chk("up.expected", 16'(expected), (c == 4'd11) ? 16'd0 : 16'(c + 4'd1));
      chk("up.locked", 16'(locked), 16'd1);
      chk("up.mismatch", 16'(mismatch), 16'd0);
      chk("up.wrap_up", 16'(wrap_up), (i == 12) ? 16'd1 : 16'd0);
      chk("up.err", 16'(err_count), 16'd0);
    end
    chk("up.wrap_up_total", 16'(wu_seen), 16'd1);

    // Reset, then count down 0,11,10,9; then loads incl. out-of-range 14.
    tick(1'b1, 1'b0, 4'd0, 1'b1, 4'd2);
    tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    chk_all("dn0", 4'd11, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd11);
    chk_all("dn1", 4'd10, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd10);
    chk_all("dn2", 4'd9, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'd7, 1'b0, 4'd9);
    chk_all("ld7", 4'd7, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd7);
    chk_all("up7", 4'd8, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'd14, 1'b1, 4'd8);
    chk_all("ld14", 4'd14, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd14);
    chk_all("c14", 4'd15, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
    chk_all("c15", 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    chk_all("c0", 4'd1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Count 1..5, glitch to 9, counter resumes at 7; three hits relock.
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b0, 4'd0, 1'b1, 4'(i));
      chk("pre.expected", 16'(expected), 16'(i + 1));
    end
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd9);
    chk_all("glitch", 4'd10, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd7);
    chk_all("lost0", 4'd8, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd8);
    chk_all("lost1", 4'd9, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd9);
    chk_all("lost2", 4'd10, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd10);
    chk_all("relock", 4'd11, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);

    // Stuck count under upd: only the first miss (in SYNC) is counted.
    tick(1'b1, 1'b0, 4'd0, 1'b1, 4'd11);
    mm_seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd3);
      mm_seen += int'(mismatch);
    end
    chk("stuck.pulses", 16'(mm_seen), 16'd1);
    chk("stuck.err", 16'(err_count), 16'd1);
    chk("stuck.locked", 16'(locked), 16'd0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd4);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    chk("stuck.still_lost", 16'(locked), 16'd0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd6);
    chk("stuck.relock", 16'(locked), 16'd1);
    chk("stuck.expected", 16'(expected), 16'd7);

    // 260 separated errors under a held load of 5: err_count saturates at 255.
    tick(1'b0, 1'b1, 4'd5, 1'b1, 4'd7);
    chk("sat.entry_locked", 16'(locked), 16'd1);
    mm_seen = 0;
    for (int i = 0; i < 260; i++) begin
      tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd6);
      mm_seen += int'(mismatch);
      repeat (3) tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd5);
    end
    chk("sat.pulses", 16'(mm_seen), 16'd260);
    chk("sat.err", 16'(err_count), 16'd255);
    chk("sat.locked", 16'(locked), 16'd1);

    // Miss and illegal value in the same cycle.
    tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd13);
    chk_all("both", 4'd5, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd5);
    chk("both.relock", 16'(locked), 16'd1);

    // Four errors, stay LOST, then reset clears everything.
    tick(1'b1, 1'b1, 4'd5, 1'b0, 4'd5);
    tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd6);
      repeat (3) tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd5);
    end
    tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd6);
    chk_all("err4", 4'd5, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'd5, 1'b0, 4'd9);
    chk_all("err4.lost", 4'd5, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 4'd5, 1'b0, 4'd13);
    chk_all("rst_lost", 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    chk_all("post_rst", 4'd1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
